// File: rtl/id_ex_stage_reg_pkg.sv
// Shared encodings for the ID/EX stage: control-word layout, opcode constants, bubble word.
// No logic; constants only.
// Control word (19 bits, LSB first): WDSel[1:0], GPRSel[3:2], DMType[6:4], ALUSrc[7],
//   NPCOp[10:8], ALUOp[15:11], MemWrite[16], RegWrite[17], bit 18 spare (carried unchanged).
package id_ex_stage_reg_pkg;

  localparam int ID_EX_CTRL_W = 19;

  localparam int CTRL_WDSEL_LSB    = 0;
  localparam int CTRL_GPRSEL_LSB   = 2;
  localparam int CTRL_DMTYPE_LSB   = 4;
  localparam int CTRL_ALUSRC_BIT   = 7;
  localparam int CTRL_NPCOP_LSB    = 8;
  localparam int CTRL_ALUOP_LSB    = 11;
  localparam int CTRL_MEMWRITE_BIT = 16;
  localparam int CTRL_REGWRITE_BIT = 17;

  localparam logic [1:0] WDSEL_FROM_ALU = 2'b00;
  localparam logic [1:0] WDSEL_FROM_MEM = 2'b01;
  localparam logic [1:0] WDSEL_FROM_PC  = 2'b10;
  localparam logic [2:0] NPC_PLUS4      = 3'b000;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  // A bubble: no register/memory write, PC+4, write-back from ALU. Encodes to all zeros.
  localparam logic [ID_EX_CTRL_W-1:0] CTRL_BUBBLE =
      (ID_EX_CTRL_W'(NPC_PLUS4) << CTRL_NPCOP_LSB) |
      (ID_EX_CTRL_W'(WDSEL_FROM_ALU) << CTRL_WDSEL_LSB);

endpackage

// File: rtl/id_ex_stage_reg_load_use.sv
// Load-use hazard detector: load in EX whose rd is read by the instruction in ID.
// Latency: purely combinational.
// Backpressure: produces the hazard term only; the top decides stall vs flush.
// Ports: ex_valid_i/ex_wdsel_i/ex_rd_i describe the EX slot; id_* describe the ID
//   instruction; haz_o is the raw hazard (not yet masked by flush).
module load_use_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic [1:0] ex_wdsel_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [6:0] id_op_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       haz_o
);

  logic use_rs1;
  logic use_rs2;
  logic ex_is_load;

  // Only formats that actually read a register field may cause a stall;
  // LUI/AUIPC/JAL carry immediate bits where rs1 would sit.
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (id_op_i)
      OP_LUI, OP_AUIPC, OP_JAL: use_rs1 = 1'b0;
      OP_R, OP_S, OP_B:         use_rs2 = 1'b1;
      default: ;
    endcase
  end

  // A load is recognised by its write-back source; x0 never carries a value.
  assign ex_is_load = ex_valid_i && (ex_wdsel_i == WDSEL_FROM_MEM) && (ex_rd_i != 5'd0);

  assign haz_o = ex_is_load && id_valid_i &&
                 ((use_rs1 && (ex_rd_i == id_rs1_i)) || (use_rs2 && (ex_rd_i == id_rs2_i)));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and perf counters.
// Latency: 1 cycle ID->EX; a load-use pair costs exactly one bubble.
// Backpressure: hold_i freezes everything; stall_o holds PC and IF/ID while a bubble enters EX.
// Ports: clk/rstn; hold_i, flush_i; id_* instruction from ID; ex_* registered EX slot;
//   stall_o (combinational); stall_cnt_o/flush_cnt_o saturating event counters.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    hold_i,
  input  logic                    flush_i,
  input  logic                    id_valid_i,
  input  logic [6:0]              id_op_i,
  input  logic [4:0]              id_rs1_i,
  input  logic [4:0]              id_rs2_i,
  input  logic [4:0]              id_rd_i,
  input  logic [ID_EX_CTRL_W-1:0] id_ctrl_i,
  input  logic [31:0]             id_pc_i,
  input  logic [31:0]             id_rd1_i,
  input  logic [31:0]             id_rd2_i,
  input  logic [31:0]             id_imm_i,
  output logic                    ex_valid_o,
  output logic [ID_EX_CTRL_W-1:0] ex_ctrl_o,
  output logic [31:0]             ex_pc_o,
  output logic [31:0]             ex_rd1_o,
  output logic [31:0]             ex_rd2_o,
  output logic [31:0]             ex_imm_o,
  output logic [4:0]              ex_rs1_o,
  output logic [4:0]              ex_rs2_o,
  output logic [4:0]              ex_rd_o,
  output logic                    stall_o,
  output logic [CNT_W-1:0]        stall_cnt_o,
  output logic [CNT_W-1:0]        flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic haz;

  load_use_detect u_load_use (
    .ex_valid_i (ex_valid_o),
    .ex_wdsel_i (ex_ctrl_o[CTRL_WDSEL_LSB +: 2]),
    .ex_rd_i    (ex_rd_o),
    .id_valid_i (id_valid_i),
    .id_op_i    (id_op_i),
    .id_rs1_i   (id_rs1_i),
    .id_rs2_i   (id_rs2_i),
    .haz_o      (haz)
  );

  // The flush kills the consumer in ID, so there is nothing left to hold back.
  assign stall_o = haz && !flush_i;

  // Flush and hazard both load a full bubble (every field zero), flush taking precedence.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= CTRL_BUBBLE;
      ex_pc_o    <= '0;
      ex_rd1_o   <= '0;
      ex_rd2_o   <= '0;
      ex_imm_o   <= '0;
      ex_rs1_o   <= '0;
      ex_rs2_o   <= '0;
      ex_rd_o    <= '0;
    end else if (!hold_i) begin
      if (flush_i || haz) begin
        ex_valid_o <= 1'b0;
        ex_ctrl_o  <= CTRL_BUBBLE;
        ex_pc_o    <= '0;
        ex_rd1_o   <= '0;
        ex_rd2_o   <= '0;
        ex_imm_o   <= '0;
        ex_rs1_o   <= '0;
        ex_rs2_o   <= '0;
        ex_rd_o    <= '0;
      end else begin
        ex_valid_o <= id_valid_i;
        ex_ctrl_o  <= id_valid_i ? id_ctrl_i : CTRL_BUBBLE;
        ex_pc_o    <= id_pc_i;
        ex_rd1_o   <= id_rd1_i;
        ex_rd2_o   <= id_rd2_i;
        ex_imm_o   <= id_imm_i;
        ex_rs1_o   <= id_rs1_i;
        ex_rs2_o   <= id_rs2_i;
        ex_rd_o    <= id_rd_i;
      end
    end
  end

  // stall_o already excludes flush cycles, so a coincident stall+flush counts as flush only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (!hold_i) begin
      if (stall_o && (stall_cnt_o != CNT_MAX)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_i && (flush_cnt_o != CNT_MAX)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule
